// File: rtl/fini_encoder_k5.sv
// Streaming FINI k5 encoder: maps 2-bit symbol pairs to 6-bit codewords,
// buffers them in a 2-entry FIFO and raises a sticky alarm if any stored
// word stops being a legal codeword.
module fini_encoder_k5 (
  input  logic       port_clk,
  input  logic       port_rst,
  input  logic [1:0] port_sym_a,
  input  logic [1:0] port_sym_b,
  input  logic       port_in_valid,
  output logic       port_in_ready,
  input  logic [5:0] port_flip,
  output logic [5:0] port_a,
  output logic [5:0] port_b,
  output logic       port_out_valid,
  input  logic       port_out_ready,
  output logic       port_alarm,
  output logic [7:0] port_count
);

  localparam int unsigned CW    = 6;
  localparam int unsigned SW    = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned OCCW  = 2;
  localparam int unsigned CNTW  = 8;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_ALARM = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     mem_a [DEPTH];
  logic [CW-1:0]     mem_b [DEPTH];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [OCCW-1:0]   occ_q;
  logic [CNTW-1:0]   count_q;

  logic              run_c;
  logic              push_c;
  logic              pop_c;
  logic              bad_c;
  logic [DEPTH-1:0]  occupied_c;

  // Symbol to k5 codeword map.
  function automatic logic [CW-1:0] enc(input logic [SW-1:0] s);
    logic [CW-1:0] c;
    case (s)
      2'd0:    c = 6'h00;
      2'd1:    c = 6'h33;
      2'd2:    c = 6'h37;
      default: c = 6'h3B;
    endcase
    return c;
  endfunction

  // Codeword predicate, identical to the downstream detector.
  function automatic logic word_ok(input logic [CW-1:0] c);
    return (c == '0) || (c[0] && c[1] && c[4] && c[5] && !(c[2] && c[3]));
  endfunction

  // Handshake decode from registered state only.
  always_comb begin
    run_c          = (state_q == ST_RUN);
    port_in_ready  = run_c && (occ_q < OCCW'(DEPTH));
    port_out_valid = run_c && (occ_q != '0);
    port_alarm     = (state_q == ST_ALARM);
    port_count     = count_q;
    port_a         = port_out_valid ? mem_a[rd_ptr_q] : '0;
    port_b         = port_out_valid ? mem_b[rd_ptr_q] : '0;
    push_c         = port_in_valid && port_in_ready;
    pop_c          = port_out_valid && port_out_ready;
  end

  // Re-check every occupied entry against the predicate.
  always_comb begin
    occupied_c = '0;
    bad_c      = 1'b0;
    if (occ_q != '0)          occupied_c[rd_ptr_q]  = 1'b1;
    if (occ_q == OCCW'(DEPTH)) occupied_c[~rd_ptr_q] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied_c[i] && (!word_ok(mem_a[i]) || !word_ok(mem_b[i]))) bad_c = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge port_clk) begin
    if (port_rst) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Next state: RUN falls into the absorbing ALARM on any bad entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bad_c) state_d = ST_ALARM;
      ST_ALARM: state_d = ST_ALARM;
      default:  state_d = ST_RUN;
    endcase
  end

  // FIFO storage, pointers, occupancy and transfer counter.
  always_ff @(posedge port_clk) begin
    if (port_rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (push_c) begin
        mem_a[wr_ptr_q] <= enc(port_sym_a) ^ port_flip;
        mem_b[wr_ptr_q] <= enc(port_sym_b);
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
        count_q  <= count_q + CNTW'(1);
      end
      if (!run_c || bad_c)      occ_q <= '0;
      else if (push_c && !pop_c) occ_q <= occ_q + OCCW'(1);
      else if (pop_c && !push_c) occ_q <= occ_q - OCCW'(1);
    end
  end

endmodule
